// File: rtl/decode_stage.sv
// RV32I decode stage for ALU-class instructions (OP, OP-IMM, LUI, AUIPC).
// One registered entry behind a valid/ready handshake; anything else is flagged illegal.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic        sel_imm,
  output logic        sel_pc,
  output logic        reg_we,
  output logic        illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // All supported opcodes end in 2'b11, so matching the full opcode also
  // rejects compressed/non-32-bit encodings.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;
  logic        funct7_base;
  logic        funct7_pair;

  alu_op_e     dec_alu;
  logic [31:0] dec_imm;
  logic        dec_sel_imm;
  logic        dec_sel_pc;
  logic        dec_illegal;
  logic        dec_reg_we;
  logic        transfer;

  assign opcode      = in_inst[6:0];
  assign funct3      = in_inst[14:12];
  assign funct7      = in_inst[31:25];
  assign funct7_base = (funct7 == F7_BASE);
  assign funct7_pair = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  // Shift amounts are zero-extended so funct7 bit 30 never reaches the ALU.
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_u  = {in_inst[31:12], 12'd0};
  assign imm_sh = {27'd0, in_inst[24:20]};

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_imm     = '0;
    dec_sel_imm = 1'b0;
    dec_sel_pc  = 1'b0;
    dec_illegal = 1'b1;

    case (opcode)
      OPC_OP: begin
        dec_illegal = !funct7_base;
        case (funct3)
          3'b000: begin
            dec_alu     = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            dec_illegal = !funct7_pair;
          end
          3'b001: dec_alu = ALU_SLL;
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b101: begin
            dec_alu     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_illegal = !funct7_pair;
          end
          3'b110: dec_alu = ALU_OR;
          default: dec_alu = ALU_AND;
        endcase
      end

      OPC_OP_IMM: begin
        dec_sel_imm = 1'b1;
        dec_imm     = imm_i;
        dec_illegal = 1'b0;
        case (funct3)
          3'b000: dec_alu = ALU_ADD;
          3'b001: begin
            dec_alu     = ALU_SLL;
            dec_imm     = imm_sh;
            dec_illegal = !funct7_base;
          end
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b101: begin
            dec_alu     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_imm     = imm_sh;
            dec_illegal = !funct7_pair;
          end
          3'b110: dec_alu = ALU_OR;
          default: dec_alu = ALU_AND;
        endcase
      end

      OPC_LUI: begin
        dec_alu     = ALU_LUI;
        dec_sel_imm = 1'b1;
        dec_imm     = imm_u;
        dec_illegal = 1'b0;
      end

      OPC_AUIPC: begin
        dec_alu     = ALU_ADD;
        dec_sel_imm = 1'b1;
        dec_sel_pc  = 1'b1;
        dec_imm     = imm_u;
        dec_illegal = 1'b0;
      end

      default: ;
    endcase

    // Illegal entries present a harmless ADD with no immediate and no writeback.
    if (dec_illegal) begin
      dec_alu     = ALU_ADD;
      dec_imm     = '0;
      dec_sel_imm = 1'b0;
      dec_sel_pc  = 1'b0;
    end
  end

  assign dec_reg_we = !dec_illegal && (in_inst[11:7] != 5'd0);
  assign in_ready   = !flush && (!out_valid || out_ready);
  assign transfer   = in_valid && in_ready;

  // Flush beats a transfer; data fields may go stale once out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      alu_ctrl  <= ALU_ADD;
      rs1_addr  <= '0;
      rs2_addr  <= '0;
      rd_addr   <= '0;
      imm       <= '0;
      sel_imm   <= 1'b0;
      sel_pc    <= 1'b0;
      reg_we    <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      alu_ctrl  <= dec_alu;
      rs1_addr  <= in_inst[19:15];
      rs2_addr  <= in_inst[24:20];
      rd_addr   <= in_inst[11:7];
      imm       <= dec_imm;
      sel_imm   <= dec_sel_imm;
      sel_pc    <= dec_sel_pc;
      reg_we    <= dec_reg_we;
      illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table-driven RV32I decode model plus
// directed vectors with hand-computed expectations.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm;
  logic        sel_imm;
  logic        sel_pc;
  logic        reg_we;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_ctrl(alu_ctrl), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .sel_imm(sel_imm), .sel_pc(sel_pc), .reg_we(reg_we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        si;
    logic        sp;
    logic        we;
    logic        ill;
  } dec_t;

  // Legal encodings as (mask, match) pairs; format 0=R 1=I 2=shift 3=LUI 4=AUIPC.
  localparam int NT = 21;
  localparam logic [31:0] T_MASK [NT] = '{
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'h0000007F, 32'h0000007F};
  localparam logic [31:0] T_MATCH [NT] = '{
    32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
    32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
    32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
    32'h00001013, 32'h00005013, 32'h40005013,
    32'h00000037, 32'h00000017};
  localparam int T_ALU [NT] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 3, 4, 5, 8, 9, 2, 6, 7, 10, 0};
  localparam int T_FMT [NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 4};

  function automatic dec_t model_decode(input logic [31:0] inst);
    dec_t d;
    d     = '0;
    d.ill = 1'b1;
    for (int i = 0; i < NT; i++) begin
      if ((inst & T_MASK[i]) == T_MATCH[i]) begin
        d.ill = 1'b0;
        d.alu = 4'(T_ALU[i]);
        case (T_FMT[i])
          1: begin d.si = 1'b1; d.imm = {{20{inst[31]}}, inst[31:20]}; end
          2: begin d.si = 1'b1; d.imm = {27'd0, inst[24:20]}; end
          3: begin d.si = 1'b1; d.imm = {inst[31:12], 12'd0}; end
          4: begin d.si = 1'b1; d.sp = 1'b1; d.imm = {inst[31:12], 12'd0}; end
          default: ;
        endcase
      end
    end
    d.we = !d.ill && (inst[11:7] != 5'd0);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Model of the single held entry, plus a log of entries handed downstream.
  bit          mv;
  logic [31:0] mpc;
  logic [31:0] minst;
  dec_t        me;
  logic [31:0] delivered[$];

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) delivered.push_back(out_pc);
    if (!rst_n) begin
      mv    <= 1'b0;
      mpc   <= '0;
      minst <= '0;
      me    <= '0;
    end else if (flush) begin
      mv <= 1'b0;
    end else if (in_valid && (!mv || out_ready)) begin
      mv    <= 1'b1;
      mpc   <= in_pc;
      minst <= in_inst;
      me    <= model_decode(in_inst);
    end else if (out_ready) begin
      mv <= 1'b0;
    end
  end

  always @(negedge clk) begin
    checkOutput("model out_valid", 32'(out_valid), 32'(mv));
    checkOutput("model in_ready", 32'(in_ready), 32'(!flush && (!mv || out_ready)));
    if (mv) begin
      checkOutput("model out_pc", out_pc, mpc);
      checkOutput("model alu_ctrl", 32'(alu_ctrl), 32'(me.alu));
      checkOutput("model rs1_addr", 32'(rs1_addr), 32'(minst[19:15]));
      checkOutput("model rs2_addr", 32'(rs2_addr), 32'(minst[24:20]));
      checkOutput("model rd_addr", 32'(rd_addr), 32'(minst[11:7]));
      checkOutput("model imm", imm, me.imm);
      checkOutput("model sel_imm", 32'(sel_imm), 32'(me.si));
      checkOutput("model sel_pc", 32'(sel_pc), 32'(me.sp));
      checkOutput("model reg_we", 32'(reg_we), 32'(me.we));
      checkOutput("model illegal", 32'(illegal), 32'(me.ill));
    end
  end

  // Drives one cycle of inputs just after a falling edge and returns at the next one.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic ordy, input logic fl, input logic rn);
    #1;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " out_pc"}, out_pc, 32'd0);
    checkOutput({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    checkOutput({tag, " rs1_addr"}, 32'(rs1_addr), 32'd0);
    checkOutput({tag, " rs2_addr"}, 32'(rs2_addr), 32'd0);
    checkOutput({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, " imm"}, imm, 32'd0);
    checkOutput({tag, " sel_imm"}, 32'(sel_imm), 32'd0);
    checkOutput({tag, " sel_pc"}, 32'(sel_pc), 32'd0);
    checkOutput({tag, " reg_we"}, 32'(reg_we), 32'd0);
    checkOutput({tag, " illegal"}, 32'(illegal), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        ill;
    logic        we;
    logic        si;
    logic        sp;
  } vec_t;

  localparam int NV = 14;
  localparam vec_t VECS [NV] = '{
    '{32'h4051D093, 32'h104, 4'd7,  32'h00000005, 1'b0, 1'b1, 1'b1, 1'b0},  // srai x1,x3,5
    '{32'h123450B7, 32'h108, 4'd10, 32'h12345000, 1'b0, 1'b1, 1'b1, 1'b0},  // lui x1
    '{32'hFFFFF117, 32'h100, 4'd0,  32'hFFFFF000, 1'b0, 1'b1, 1'b1, 1'b1},  // auipc x2
    '{32'h403110B3, 32'h110, 4'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0},  // sll with funct7 0100000
    '{32'h403100B3, 32'h114, 4'd1,  32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0},  // sub x1,x2,x3
    '{32'h00000013, 32'h118, 4'd0,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0},  // addi x0,x0,0
    '{32'hFFF10093, 32'h11C, 4'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0},  // addi x1,x2,-1
    '{32'h02109093, 32'h120, 4'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0},  // slli with inst[25] set
    '{32'h003100B1, 32'h124, 4'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0},  // low bits 01
    '{32'h80023193, 32'h128, 4'd4,  32'hFFFFF800, 1'b0, 1'b1, 1'b1, 1'b0},  // sltiu x3,x4,-2048
    '{32'h407352B3, 32'h12C, 4'd7,  32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0},  // sra x5,x6,x7
    '{32'h0020FFB3, 32'h130, 4'd9,  32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0},  // and x31,x1,x2
    '{32'h01F0D093, 32'h134, 4'd6,  32'h0000001F, 1'b0, 1'b1, 1'b1, 1'b0},  // srli x1,x1,31
    '{32'h0020A023, 32'h138, 4'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}   // sw (unsupported)
  };

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkReset("reset");

    applyStimulus(1'b1, 32'h003100B3, 32'h100, 1'b1, 1'b0, 1'b1);
    checkOutput("add out_valid", 32'(out_valid), 32'd1);
    checkOutput("add alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("add rs1_addr", 32'(rs1_addr), 32'd2);
    checkOutput("add rs2_addr", 32'(rs2_addr), 32'd3);
    checkOutput("add rd_addr", 32'(rd_addr), 32'd1);
    checkOutput("add sel_imm", 32'(sel_imm), 32'd0);
    checkOutput("add reg_we", 32'(reg_we), 32'd1);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, VECS[i].inst, VECS[i].pc, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d out_pc", i), out_pc, VECS[i].pc);
      checkOutput($sformatf("vec%0d alu_ctrl", i), 32'(alu_ctrl), 32'(VECS[i].alu));
      checkOutput($sformatf("vec%0d imm", i), imm, VECS[i].imm);
      checkOutput($sformatf("vec%0d illegal", i), 32'(illegal), 32'(VECS[i].ill));
      checkOutput($sformatf("vec%0d reg_we", i), 32'(reg_we), 32'(VECS[i].we));
      checkOutput($sformatf("vec%0d sel_imm", i), 32'(sel_imm), 32'(VECS[i].si));
      checkOutput($sformatf("vec%0d sel_pc", i), 32'(sel_pc), 32'(VECS[i].sp));
    end

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    delivered.delete();

    // Backpressure: first entry held for three cycles while two more wait.
    applyStimulus(1'b1, 32'h003100B3, 32'h200, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h4051D093, 32'h204, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d out_pc", i), out_pc, 32'h200);
      checkOutput($sformatf("stall%0d alu_ctrl", i), 32'(alu_ctrl), 32'd0);
    end
    applyStimulus(1'b1, 32'h4051D093, 32'h204, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h123450B7, 32'h208, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("order count", 32'(delivered.size()), 32'd3);
    if (delivered.size() == 3) begin
      checkOutput("order pc0", delivered[0], 32'h200);
      checkOutput("order pc1", delivered[1], 32'h204);
      checkOutput("order pc2", delivered[2], 32'h208);
    end
    delivered.delete();

    // Flush with an entry held and a new one offered.
    applyStimulus(1'b1, 32'h003100B3, 32'h300, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h123450B7, 32'h304, 1'b0, 1'b1, 1'b1);
    checkOutput("flush in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("after flush out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush delivered", 32'(delivered.size()), 32'd0);

    // Reset mid-stream drops the held entry.
    applyStimulus(1'b1, 32'h123450B7, 32'h400, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hFFFFF117, 32'h404, 1'b1, 1'b0, 1'b0);
    checkReset("midreset");
    applyStimulus(1'b1, 32'h003100B3, 32'h500, 1'b1, 1'b0, 1'b1);
    checkOutput("recover out_valid", 32'(out_valid), 32'd1);
    checkOutput("recover out_pc", out_pc, 32'h500);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("reset delivered", 32'(delivered.size()), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
